// File: rtl/qr_result_serializer_pkg.sv
// qr_result_serializer_pkg: shared record layout, field offsets and FSM encodings
package qr_result_serializer_pkg;
    localparam int REC_W    = 480;
    localparam int YHAT_W   = 160;
    localparam int R_W      = 320;
    localparam int YHAT_LSB = 0;
    localparam int R_LSB    = YHAT_LSB + YHAT_W;
    localparam int LAST_BIT = REC_W;
    typedef struct packed {
        logic              last;
        logic [R_W-1:0]    r;
        logic [YHAT_W-1:0] y_hat;
    } rec_t;
    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;
endpackage

// File: rtl/qr_rec_fifo.sv
// qr_rec_fifo: DEPTH x record register FIFO; a push while full succeeds only alongside a pop
module qr_rec_fifo
    import qr_result_serializer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic push,
    input  logic pop,
    input  rec_t din,
    output logic full,
    output logic empty,
    output logic two,
    output rec_t head,
    output rec_t nxt
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]   wr_ptr, rd_ptr, cnt;
    logic [AW-1:0] ra, ra1;
    logic          wr_en;
    rec_t          mem [DEPTH];
    assign cnt   = wr_ptr - rd_ptr;
    assign empty = cnt == '0;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign two   = cnt > (AW+1)'(1);
    assign wr_en = push & (~full | pop);
    assign ra    = rd_ptr[AW-1:0];
    assign ra1   = ra + 1'b1;
    assign head  = mem[ra];
    assign nxt   = mem[ra1];
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop & ~empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/qr_result_serializer.sv
// qr_result_serializer: buffers QR result records and streams them as OUT_W words with markers
module qr_result_serializer
    import qr_result_serializer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OUT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rd_vld,
    input  logic             i_last_data,
    input  logic [159:0]     i_y_hat,
    input  logic [319:0]     i_r,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sor,
    output logic             o_eor,
    output logic             o_eof,
    output logic             o_overflow,
    output logic [3:0]       o_rec_idx
);
    localparam int WPR = REC_W / OUT_W;
    localparam int KW  = $clog2(WPR);
    localparam logic [KW-1:0] K_LAST = KW'(WPR - 1);
    state_t                     state, state_nxt;
    logic [KW-1:0]              k, k_nxt;
    logic [REC_W:0]             rec_bits;
    rec_t                       head, nxt, hd_nxt;
    logic [WPR-1:0][OUT_W-1:0]  words;
    logic                       full, empty, two, hs, pop, valid_nxt;
    always_comb begin
        rec_bits                       = '0;
        rec_bits[YHAT_LSB +: YHAT_W]   = i_y_hat;
        rec_bits[R_LSB +: R_W]         = i_r;
        rec_bits[LAST_BIT]             = i_last_data;
    end
    assign hs  = o_valid & i_ready;
    assign pop = hs & (k == K_LAST);
    qr_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (i_rd_vld),
        .pop   (pop),
        .din   (rec_t'(rec_bits)),
        .full  (full),
        .empty (empty),
        .two   (two),
        .head  (head),
        .nxt   (nxt)
    );
    // the word after a pop comes from the second entry so back-to-back records have no bubble
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        hd_nxt    = head;
        if (state == S_IDLE) begin
            state_nxt = empty ? S_IDLE : S_SEND;
            k_nxt     = '0;
        end else if (pop) begin
            state_nxt = two ? S_SEND : S_IDLE;
            k_nxt     = '0;
            hd_nxt    = nxt;
        end else if (hs) begin
            k_nxt = k + 1'b1;
        end
        valid_nxt = state_nxt == S_SEND;
        words     = hd_nxt[REC_W-1:0];
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            k          <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_sor      <= 1'b0;
            o_eor      <= 1'b0;
            o_eof      <= 1'b0;
            o_overflow <= 1'b0;
            o_rec_idx  <= '0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            o_valid    <= valid_nxt;
            o_data     <= valid_nxt ? words[k_nxt] : '0;
            o_sor      <= valid_nxt & (k_nxt == '0);
            o_eor      <= valid_nxt & (k_nxt == K_LAST);
            o_eof      <= valid_nxt & (k_nxt == K_LAST) & hd_nxt.last;
            o_overflow <= o_overflow | (i_rd_vld & full & ~pop);
            o_rec_idx  <= pop ? (head.last ? 4'd0 : o_rec_idx + 4'd1) : o_rec_idx;
        end
    end
endmodule

// File: tb/tb_qr_result_serializer.sv
// tb_qr_result_serializer: directed scenario tests for qr_result_serializer (DEPTH=2, OUT_W=32)
module tb_qr_result_serializer;
    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_rd_vld = 1'b0;
    logic         i_last_data = 1'b0;
    logic [159:0] i_y_hat = '0;
    logic [319:0] i_r = '0;
    logic         ready = 1'b0;
    logic         o_valid, o_sor, o_eor, o_eof, o_overflow;
    logic [31:0]  o_data;
    logic [3:0]   o_rec_idx;
    int           checks = 0;
    int           failures = 0;
    int           exp_idx = 0;

    qr_result_serializer #(.DEPTH(2), .OUT_W(32)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_rd_vld    (i_rd_vld),
        .i_last_data (i_last_data),
        .i_y_hat     (i_y_hat),
        .i_r         (i_r),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_data      (o_data),
        .o_sor       (o_sor),
        .o_eor       (o_eor),
        .o_eof       (o_eof),
        .o_overflow  (o_overflow),
        .o_rec_idx   (o_rec_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [480:0] mk(input logic [7:0] s, input logic last);
        logic [480:0] v;
        v[159:0] = 160'h0123456789abcdeffedcba98765432100f1e2d3c ^ {20{s}};
        for (int i = 0; i < 40; i++) v[160 + i*8 +: 8] = 8'(i) + s;
        v[480] = last;
        return v;
    endfunction

    task automatic push(input logic [480:0] rec);
        i_rd_vld    = 1'b1;
        i_y_hat     = rec[159:0];
        i_r         = rec[479:160];
        i_last_data = rec[480];
        @(negedge clk);
        i_rd_vld    = 1'b0;
        i_last_data = 1'b1;
    endtask

    task automatic recv(input logic [480:0] rec, input int pct, input string tag);
        int k = 0;
        int budget = 0;
        logic [3:0] idx = 4'(exp_idx);
        while (k < 15 && budget < 3000) begin
            ready = ($urandom_range(99, 0) < pct);
            if (o_valid) begin
                checks++;
                if (o_data !== rec[k*32 +: 32] || o_sor !== (k == 0) || o_eor !== (k == 14) ||
                    o_eof !== (k == 14 && rec[480]) || o_rec_idx !== idx) begin
                    failures++;
                    $display("FAIL %s word %0d: got data=%h sor=%b eor=%b eof=%b idx=%0d, want data=%h sor=%b eor=%b eof=%b idx=%0d",
                             tag, k, o_data, o_sor, o_eor, o_eof, o_rec_idx,
                             rec[k*32 +: 32], k == 0, k == 14, k == 14 && rec[480], idx);
                end
                if (ready) k++;
            end
            budget++;
            @(negedge clk);
        end
        if (k < 15) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got %0d words, want 15", tag, k);
        end
        exp_idx = rec[480] ? 0 : (exp_idx + 1) % 16;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_valid, o_data, o_sor, o_eor, o_eof, o_overflow, o_rec_idx} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b data=%h sor=%b eor=%b eof=%b ovf=%b idx=%0d, want all 0",
                     o_valid, o_data, o_sor, o_eor, o_eof, o_overflow, o_rec_idx);
        end
        i_rst = 1'b0;
        exp_idx = 0;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [480:0] r = mk(8'h00, 1'b0);
        ready = 1'b1;
        push(r);
        chk("single_latency_idle", {63'd0, o_valid}, 64'd0);
        @(negedge clk);
        chk("single_latency_valid", {63'd0, o_valid}, 64'd1);
        recv(r, 100, "single");
        chk("single_after_valid", {63'd0, o_valid}, 64'd0);
        chk("single_after_markers", {61'd0, o_sor, o_eor, o_eof}, 64'd0);
        chk("single_rec_idx", {60'd0, o_rec_idx}, 64'd1);
    endtask

    task automatic test_frame;
        for (int i = 0; i < 10; i++) begin
            logic [480:0] r = mk(8'(8'h10 + i), i == 9);
            push(r);
            @(negedge clk);
            recv(r, 100, $sformatf("frame%0d", i));
            repeat (184) @(negedge clk);
        end
        chk("frame_rec_idx_wrap", {60'd0, o_rec_idx}, 64'd0);
        chk("frame_overflow", {63'd0, o_overflow}, 64'd0);
    endtask

    task automatic test_back_pressure;
        logic [480:0] a = mk(8'h31, 1'b0);
        logic [480:0] b = mk(8'h47, 1'b1);
        ready = 1'b0;
        push(a);
        push(b);
        recv(a, 30, "bp_a");
        recv(b, 30, "bp_b");
        chk("bp_drain", {63'd0, o_valid}, 64'd0);
        chk("bp_rec_idx", {60'd0, o_rec_idx}, 64'd0);
    endtask

    task automatic test_overflow;
        logic [480:0] r1 = mk(8'h51, 1'b0);
        logic [480:0] r2 = mk(8'h62, 1'b1);
        logic [480:0] r3 = mk(8'h73, 1'b0);
        ready = 1'b0;
        push(r1);
        push(r2);
        chk("ovf_before", {63'd0, o_overflow}, 64'd0);
        push(r3);
        chk("ovf_set", {63'd0, o_overflow}, 64'd1);
        recv(r1, 100, "ovf_r1");
        recv(r2, 100, "ovf_r2");
        chk("ovf_no_third", {63'd0, o_valid}, 64'd0);
        repeat (3) @(negedge clk);
        chk("ovf_still_idle", {63'd0, o_valid}, 64'd0);
        chk("ovf_sticky", {63'd0, o_overflow}, 64'd1);
    endtask

    task automatic test_full_pop;
        logic [480:0] r1 = mk(8'h81, 1'b0);
        logic [480:0] r2 = mk(8'h92, 1'b0);
        logic [480:0] r3 = mk(8'ha3, 1'b0);
        test_reset();
        ready = 1'b0;
        push(r1);
        push(r2);
        ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("fp_r1_word%0d", k), {31'd0, o_valid, o_data}, {31'd0, 1'b1, r1[k*32 +: 32]});
            @(negedge clk);
        end
        chk("fp_r1_last", {30'd0, o_eor, o_sor, o_data}, {30'd0, 2'b10, r1[14*32 +: 32]});
        i_rd_vld    = 1'b1;
        i_y_hat     = r3[159:0];
        i_r         = r3[479:160];
        i_last_data = r3[480];
        @(negedge clk);
        i_rd_vld = 1'b0;
        exp_idx  = 1;
        chk("fp_no_overflow", {63'd0, o_overflow}, 64'd0);
        recv(r2, 100, "fp_r2");
        chk("fp_no_bubble", {62'd0, o_valid, o_sor}, 64'd3);
        recv(r3, 100, "fp_r3");
        chk("fp_rec_idx", {60'd0, o_rec_idx}, 64'd3);
    endtask

    task automatic test_reset_mid;
        logic [480:0] r  = mk(8'hb4, 1'b0);
        logic [480:0] r2 = mk(8'hc5, 1'b1);
        ready = 1'b1;
        push(r);
        @(negedge clk);
        repeat (7) @(negedge clk);
        chk("rm_word7", {31'd0, o_valid, o_data}, {31'd0, 1'b1, r[7*32 +: 32]});
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_data, o_sor, o_eor, o_eof, o_overflow, o_rec_idx} !== '0) begin
            failures++;
            $display("FAIL rm_async_clear: got valid=%b data=%h idx=%0d, want all 0", o_valid, o_data, o_rec_idx);
        end
        @(negedge clk);
        i_rst   = 1'b0;
        exp_idx = 0;
        repeat (3) @(negedge clk);
        chk("rm_discarded", {63'd0, o_valid}, 64'd0);
        push(r2);
        @(negedge clk);
        recv(r2, 100, "rm_new");
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_back_pressure();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qr_result_serializer.md
Name: qr_result_serializer

Overview:
- Downstream consumer of the QR engine result interface (rd_vld / last_data / y_hat / r).
- Captures each 480-bit result record (160-bit y_hat + 320-bit R) on the valid pulse and buffers it in a small FIFO.
- Streams each record out as fixed-width words over a valid/ready bus toward the output collector, with record and frame markers.
- Decouples the engine's single-cycle result pulse from a back-pressured narrow link.

Parameters:
- DEPTH, 2, number of buffered 480-bit records; power of two, minimum 2.
- OUT_W, 32, output word width; must divide 480 (legal: 16, 32, 48, 96, 160).
- Derived constant WPR = 480/OUT_W words per record (15 at default).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rd_vld  in  1  single-cycle result-valid pulse from the engine.
- i_last_data  in  1  qualifies i_rd_vld: record is the last of its frame.
- i_y_hat  in  160  y_hat result, sampled when i_rd_vld=1.
- i_r  in  320  R result, sampled when i_rd_vld=1.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the word when o_valid & i_ready.
- o_data  out  OUT_W  output word.
- o_sor  out  1  word is the first word of a record.
- o_eor  out  1  word is the last word of a record.
- o_eof  out  1  word is the last word of a record tagged last_data.
- o_overflow  out  1  sticky: a record was dropped.
- o_rec_idx  out  4  index of the record currently being sent within its frame (0..15, wraps).

Behaviour:
- Reset values: o_valid=0, o_data=0, o_sor=0, o_eor=0, o_eof=0, o_overflow=0, o_rec_idx=0. FIFO empty; word counter 0. Reset asserted mid-record aborts the record and discards all buffered data.
- Record packing: rec[159:0]=i_y_hat, rec[479:160]=i_r, rec[480]=i_last_data. Word k (0..WPR-1) = rec[k*OUT_W +: OUT_W], k=0 sent first.
- Write: on a cycle with i_rd_vld=1 and the FIFO not full, capture the record at the clock edge and increment the write pointer.
- Write when full: drop the record, set o_overflow (cleared only by reset), and leave the FIFO unchanged.
- Exception to the full rule: if the FIFO is full and the final word (k=WPR-1) is accepted in the same cycle, the write succeeds and there is no overflow.
- Read FSM: two states, S_IDLE and S_SEND.
  - S_IDLE: o_valid=0. Moves to S_SEND the cycle after the FIFO becomes non-empty.
  - Latency: i_rd_vld at edge N gives o_valid=1 with word 0 after edge N+1.
  - S_SEND: o_valid=1 and o_data=word k of the head record. Registered outputs; o_data is stable while o_valid & ~i_ready.
  - On handshake with k<WPR-1: k is incremented.
  - On handshake with k=WPR-1: pop the head, set k=0, and increment o_rec_idx (reset to 0 if the popped record had last=1). Stay in S_SEND if another record is buffered, with no bubble; otherwise go to S_IDLE.
- Markers:
  - o_sor=1 when k=0.
  - o_eor=1 when k=WPR-1.
  - o_eof=o_eor & head.last.
  - All markers are 0 when o_valid=0.
- o_valid never drops without a handshake once asserted.
- i_last_data is ignored when i_rd_vld=0.
- Pointers: log2(DEPTH)+1 bits. Full when MSBs differ and the remaining bits are equal. Wrap-around is natural modulo.

Decomposition:
- Shared package holds:
  - REC_W=480, YHAT_W=160, R_W=320.
  - Field offsets for y_hat and R.
  - The record-type bit layout (with the last flag at bit 480).
  - The S_IDLE/S_SEND encodings.
- One sub-module, qr_rec_fifo: a DEPTH x 481 register FIFO with push/pop/full/empty/head.
- The top level holds the word counter, the FSM, the marker logic and the overflow flag.

Test Plan:
- Single record: y_hat=160'h0123…, R=incrementing bytes, last=0, i_ready=1 → o_valid rises 1 cycle later. 15 consecutive words match rec slices. o_sor on word 0 only, o_eor on word 14, o_eof=0, o_rec_idx goes 0→1.
- Frame of 10: ten records spaced 201 cycles apart, the tenth with last=1, ready always high → 150 words. o_eof only on word 149. o_rec_idx returns to 0 after it. o_overflow=0.
- Back-pressure: i_ready toggled pseudo-randomly at 30% → o_data/markers held stable while stalled, no word lost or duplicated, order correct.
- Overflow: i_ready=0, three records pushed (DEPTH=2) → o_overflow=1 after the third. Releasing ready yields exactly records 1 and 2.
- Full + simultaneous pop: FIFO full, third i_rd_vld in the same cycle word 14 is accepted → no overflow, third record follows record 2 with no idle cycle.
- Reset mid-record: assert i_rst at word 7 → all outputs are 0 immediately. After release, a new record streams from word 0 with o_rec_idx=0.
